fpu_req_scheduler: RTL

//  Shares one FPU (add/sub/mul/div, one-cycle registered result on start) among NREQ requesters.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/fpu_req_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants and state encoding for the FPU request scheduler
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter starting its search at ptr
//
// Ports:
//   req     request bits, one per requester
//   ptr     highest-priority requester index (must be < NREQ)
//   en      when low no grant is issued
//   gnt     one-hot grant (all zero when nothing is granted)
//   gnt_id  index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id
);

    localparam int IDW = $clog2(NREQ);

    // One extra bit so ptr+k never overflows before the wrap at NREQ,
    // which matters when NREQ is not a power of two.
    logic [IDW:0] idx;
    logic         found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (en && !found && req[idx[IDW-1:0]]) begin
                gnt[idx[IDW-1:0]] = 1'b1;
                gnt_id            = idx[IDW-1:0];
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_req_scheduler.sv
// rtl/fpu_req_scheduler.sv - round-robin sharing of one FPU among NREQ requesters
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   req_valid/req_ready                 per-requester handshake (req_ready one-hot)
//   req_a/req_b/req_sel/req_rmode       packed per-requester operands and controls
//   rsp_valid/rsp_ready                 response handshake
//   rsp_id/rsp_y/rsp_error/rsp_overflow response payload tagged with requester id
//   fpu_start/fpu_a/fpu_b/fpu_sel/fpu_rmode  FPU command side, operands registered
//   fpu_y/fpu_error/fpu_overflow        FPU result side
//   busy                                high whenever an operation is in progress
module fpu_req_scheduler
    import fpu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int FPU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0] req_sel,
    input  logic [NREQ*2-1:0] req_rmode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_y,
    output logic              rsp_error,
    output logic              rsp_overflow,
    output logic              fpu_start,
    output logic [31:0]       fpu_a,
    output logic [31:0]       fpu_b,
    output logic [1:0]        fpu_sel,
    output logic [1:0]        fpu_rmode,
    input  logic [31:0]       fpu_y,
    input  logic              fpu_error,
    input  logic              fpu_overflow,
    output logic              busy
);

    localparam int WCW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [1:0]     sel_q, sel_d, rmode_q, rmode_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [31:0]    y_q, y_d;
    logic           err_q, err_d, ovf_q, ovf_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            arb_en;

    // Gating with reset_n keeps req_ready low while reset is held, even if
    // requesters keep their valids asserted.
    assign arb_en = (state_q == S_IDLE) && reset_n;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        rmode_d  = rmode_q;
        wcnt_d   = wcnt_q;
        y_d      = y_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                // A grant is only issued to a valid requester, so any grant is a handshake.
                if (|gnt) begin
                    id_d     = gnt_id;
                    rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            a_d     = req_a[32*i +: 32];
                            b_d     = req_b[32*i +: 32];
                            sel_d   = req_sel[2*i +: 2];
                            rmode_d = req_rmode[2*i +: 2];
                        end
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = WCW'(FPU_LAT-1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    y_d     = fpu_y;
                    err_d   = fpu_error;
                    ovf_d   = fpu_overflow;
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            rmode_q  <= '0;
            wcnt_q   <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            rmode_q  <= rmode_d;
            wcnt_q   <= wcnt_d;
            y_q      <= y_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign req_ready    = gnt;
    assign fpu_start    = (state_q == S_ISSUE);
    assign rsp_valid    = (state_q == S_RESP);
    assign busy         = (state_q != S_IDLE);
    assign fpu_a        = a_q;
    assign fpu_b        = b_q;
    assign fpu_sel      = sel_q;
    assign fpu_rmode    = rmode_q;
    assign rsp_id       = id_q;
    assign rsp_y        = y_q;
    assign rsp_error    = err_q;
    assign rsp_overflow = ovf_q;

endmodule
